// File: rtl/sipo_deserializer_if.sv
// Bundle of the serial input and parallel output signals of sipo_deserializer.
// The receiver uses the slave modport. The serial source and word consumer use the master modport.
interface sipo_deserializer_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             sin;
   logic             sin_valid;
   logic             sync;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic [CW-1:0]    bit_cnt;
   logic             overrun;

   // Handshake: a word transfers on an edge where dout_valid=1 and dout_ready=1. dout is stable
   // while it waits. The serial side has no backpressure: sin is taken on every edge with sin_valid=1.
   modport master (
      output sin, sin_valid, sync, dout_ready,
      input  dout, dout_valid, bit_cnt, overrun
   );

   modport slave (
      input  sin, sin_valid, sync, dout_ready,
      output dout, dout_valid, bit_cnt, overrun
   );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out receiver. It assembles WIDTH qualified serial bits into one word and
// presents the word through a single-entry output buffer. A word that cannot be delivered sets a sticky overrun flag.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   sipo_deserializer_if.slave   bus,
   output logic                 dbg_state_o
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      ASSEMBLE = 1'b0,
      HOLD     = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-2:0] part_q, part_d;
   logic [WIDTH-2:0] part_base;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             overrun_q, overrun_d;
   logic             complete;

   // The partial register keeps only the WIDTH-1 most recent bits.
   // The incoming bit completes the full-width view 'word'.
   always_comb begin
      part_base = bus.sync ? '0 : part_q;
      if (MSB_FIRST) begin
         word = {part_base, bus.sin};
      end else begin
         word = {bus.sin, part_base};
      end

      complete  = bus.sin_valid && !bus.sync && (bit_cnt_q == CW'(WIDTH - 1));
      part_d    = part_q;
      bit_cnt_d = bit_cnt_q;

      if (bus.sin_valid) begin
         part_d = MSB_FIRST ? word[WIDTH-2:0] : word[WIDTH-1:1];
         if (complete) begin
            bit_cnt_d = '0;
         end else if (bus.sync) begin
            bit_cnt_d = CW'(1);
         end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
         end
      end else if (bus.sync) begin
         part_d    = '0;
         bit_cnt_d = '0;
      end
   end

   // HOLD means the output buffer holds an undelivered word. Assembly runs in both states.
   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      overrun_d = overrun_q;

      case (state_q)
         ASSEMBLE: begin
            if (complete) begin
               dout_d  = word;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (complete) begin
               if (bus.dout_ready) begin
                  dout_d = word;
               end else begin
                  overrun_d = 1'b1;
               end
            end else if (bus.dout_ready) begin
               state_d = ASSEMBLE;
            end
         end
         default: begin
            state_d = ASSEMBLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ASSEMBLE;
         part_q    <= '0;
         bit_cnt_q <= '0;
         dout_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         part_q    <= part_d;
         bit_cnt_q <= bit_cnt_d;
         dout_q    <= dout_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = (state_q == HOLD);
   assign bus.bit_cnt    = bit_cnt_q;
   assign bus.overrun    = overrun_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer. An MSB-first and an LSB-first instance share one stimulus stream.
// Both are compared against a bit-list reference model.
module tb_sipo_deserializer;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);
   localparam int OW = W + CW + 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sin = 1'b0, sin_valid = 1'b0, sync = 1'b0, dout_ready = 1'b0;
   logic dbg_m, dbg_l;

   sipo_deserializer_if #(.WIDTH(W)) if_m ();
   sipo_deserializer_if #(.WIDTH(W)) if_l ();

   assign if_m.sin = sin;  assign if_m.sin_valid = sin_valid;
   assign if_m.sync = sync; assign if_m.dout_ready = dout_ready;
   assign if_l.sin = sin;  assign if_l.sin_valid = sin_valid;
   assign if_l.sync = sync; assign if_l.dout_ready = dout_ready;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .bus(if_m), .dbg_state_o(dbg_m)
   );
   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .bus(if_l), .dbg_state_o(dbg_l)
   );

   // clock / reset
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   // Reference model. Index 1 is the MSB-first instance and index 0 is the LSB-first instance.
   logic         mb [2][W];
   int           mn [2];
   logic [W-1:0] md [2];
   logic         mv [2];
   logic         mo [2];
   logic [W-1:0] exp_q[$];

   logic [OW-1:0] obs_m, obs_l;
   assign obs_m = {if_m.dout, if_m.dout_valid, if_m.bit_cnt, if_m.overrun};
   assign obs_l = {if_l.dout, if_l.dout_valid, if_l.bit_cnt, if_l.overrun};

   function automatic logic [OW-1:0] exp_vec(input int k);
      return {md[k], mv[k], CW'(mn[k]), mo[k]};
   endfunction

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         logic consumed;
         logic completed;
         logic [W-1:0] w;
         if (!reset) begin
            mn[k] = 0; md[k] = '0; mv[k] = 1'b0; mo[k] = 1'b0;
            if (k == 1) exp_q.delete();
            continue;
         end
         consumed  = mv[k] && dout_ready;
         completed = 1'b0;
         w = '0;
         if (sync) mn[k] = 0;
         if (sin_valid) begin
            mb[k][mn[k]] = sin;
            mn[k]++;
         end
         if (mn[k] == W) begin
            for (int i = 0; i < W; i++) begin
               if (k == 1) w[W-1-i] = mb[k][i];
               else        w[i]     = mb[k][i];
            end
            mn[k] = 0;
            completed = 1'b1;
         end
         if (completed) begin
            if (!mv[k] || consumed) begin
               md[k] = w;
               mv[k] = 1'b1;
               if (k == 1) exp_q.push_back(w);
            end else begin
               mo[k] = 1'b1;
            end
         end else if (consumed) begin
            mv[k] = 1'b0;
         end
      end
   endtask

   // driver: apply inputs, take one rising edge, then stop at the falling edge for sampling
   task automatic step(input logic s, input logic v, input logic sy, input logic rdy);
      sin = s; sin_valid = v; sync = sy; dout_ready = rdy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      vectors++;
      if (obs_m !== '0 || obs_l !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got m=%h l=%h, need 0", obs_m, obs_l);
      end
      vectors++;
      if (dbg_m !== 1'b0 || dbg_l !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got m=%b l=%b, need 0", dbg_m, dbg_l);
      end
      reset = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] pat;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         step(pat[7-i], 1'b1, 1'b0, 1'b1);
         vectors++;
         if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
            errors++;
            $display("FAIL basic_bit%0d: got m=%h l=%h, need m=%h l=%h", i, obs_m, obs_l, exp_vec(1), exp_vec(0));
         end
      end
      vectors++;
      if (if_m.dout !== 8'hA5 || if_l.dout !== 8'hA5 || !if_m.dout_valid || !if_l.dout_valid || if_m.overrun !== 1'b0) begin
         errors++;
         $display("FAIL basic_a5: got m=%h l=%h v=%b%b, need A5 A5 v=11", if_m.dout, if_l.dout, if_m.dout_valid, if_l.dout_valid);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (if_m.dout_valid !== 1'b0 || if_m.dout !== 8'hA5) begin
         errors++;
         $display("FAIL basic_drain: got v=%b d=%h, need v=0 d=a5", if_m.dout_valid, if_m.dout);
      end
      pat = 8'h80;
      for (int i = 0; i < 8; i++) step(pat[7-i], 1'b1, 1'b0, 1'b1);
      vectors++;
      if (if_m.dout !== 8'h80 || if_l.dout !== 8'h01 || obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
         errors++;
         $display("FAIL basic_order: got m=%h l=%h, need m=80 l=01", if_m.dout, if_l.dout);
      end
   endtask

   task automatic test_gap();
      logic [7:0] pat;
      pat = 8'h3C;
      for (int i = 0; i < 4; i++) step(pat[7-i], 1'b1, 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) begin
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
         vectors++;
         if (if_m.bit_cnt !== 4'd4 || obs_l !== exp_vec(0)) begin
            errors++;
            $display("FAIL gap_hold%0d: got bit_cnt=%0d, need 4", g, if_m.bit_cnt);
         end
      end
      for (int i = 4; i < 8; i++) step(pat[7-i], 1'b1, 1'b0, 1'b1);
      vectors++;
      if (if_m.dout !== 8'h3C || obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
         errors++;
         $display("FAIL gap_word: got %h, need 3c", if_m.dout);
      end
   endtask

   task automatic test_overrun();
      logic [7:0] a, b;
      a = 8'h5A; b = 8'hC3;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(a[7-i], 1'b1, 1'b0, 1'b0);
      vectors++;
      if (if_m.dout !== 8'h5A || if_m.dout_valid !== 1'b1 || if_m.overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_first: got d=%h v=%b o=%b, need 5a 1 0", if_m.dout, if_m.dout_valid, if_m.overrun);
      end
      for (int i = 0; i < 8; i++) begin
         step(b[7-i], 1'b1, 1'b0, 1'b0);
         vectors++;
         if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
            errors++;
            $display("FAIL ovr_bit%0d: got m=%h l=%h, need m=%h l=%h", i, obs_m, obs_l, exp_vec(1), exp_vec(0));
         end
      end
      vectors++;
      if (if_m.dout !== 8'h5A || if_m.overrun !== 1'b1 || if_m.bit_cnt !== 4'd0) begin
         errors++;
         $display("FAIL ovr_drop: got d=%h o=%b c=%0d, need 5a 1 0", if_m.dout, if_m.overrun, if_m.bit_cnt);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (if_m.dout_valid !== 1'b0 || if_m.overrun !== 1'b1 || obs_m !== exp_vec(1)) begin
         errors++;
         $display("FAIL ovr_sticky: got v=%b o=%b, need 0 1", if_m.dout_valid, if_m.overrun);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      a = 8'h5A; b = 8'h96;
      do_reset();
      for (int i = 0; i < 8; i++) step(a[7-i], 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(b[7-i], 1'b1, 1'b0, (i == 7));
         vectors++;
         if (if_m.dout_valid !== 1'b1 || obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
            errors++;
            $display("FAIL b2b_bit%0d: got m=%h, need m=%h", i, obs_m, exp_vec(1));
         end
      end
      vectors++;
      if (if_m.dout !== 8'h96 || if_m.overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_replace: got d=%h o=%b, need 96 0", if_m.dout, if_m.overrun);
      end
   endtask

   task automatic test_sync();
      logic [7:0] pat;
      pat = 8'hF0;
      do_reset();
      for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
      step(pat[7], 1'b1, 1'b1, 1'b1);
      vectors++;
      if (if_m.bit_cnt !== 4'd1 || if_m.dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL sync_start: got c=%0d v=%b, need 1 0", if_m.bit_cnt, if_m.dout_valid);
      end
      for (int i = 6; i >= 0; i--) begin
         step(pat[i], 1'b1, 1'b0, 1'b1);
         vectors++;
         if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
            errors++;
            $display("FAIL sync_bit%0d: got m=%h, need m=%h", i, obs_m, exp_vec(1));
         end
      end
      vectors++;
      if (if_m.dout !== 8'hF0 || if_m.dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL sync_word: got d=%h v=%b, need f0 1", if_m.dout, if_m.dout_valid);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (if_m.bit_cnt !== 4'd0 || obs_m !== exp_vec(1)) begin
         errors++;
         $display("FAIL sync_clear: got c=%0d, need 0", if_m.bit_cnt);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] pat;
      pat = 8'($urandom_range(0, 255));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b0, 1'b1);
      vectors++;
      if (obs_m !== '0 || obs_l !== '0) begin
         errors++;
         $display("FAIL midrst_zero: got m=%h l=%h, need 0", obs_m, obs_l);
      end
      reset = 1'b1;
      for (int i = 0; i < 8; i++) step(pat[7-i], 1'b1, 1'b0, 1'b0);
      vectors++;
      if (if_m.dout !== pat || if_m.dout_valid !== 1'b1 || obs_l !== exp_vec(0)) begin
         errors++;
         $display("FAIL midrst_word: got %h, need %h", if_m.dout, pat);
      end
   endtask

   // randomized traffic with a scoreboard on the words delivered by the MSB-first instance
   task automatic test_random();
      logic s, v, sy, rdy;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         s   = 1'($urandom_range(0, 1));
         v   = ($urandom_range(0, 3) != 0);
         sy  = ($urandom_range(0, 40) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         reset = ($urandom_range(0, 400) != 0);
         if (reset && if_m.dout_valid && rdy) begin
            vectors++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_deliver_%0d: got %h, need nothing pending", n, if_m.dout);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (if_m.dout !== e) begin
                  errors++;
                  $display("FAIL rand_deliver_%0d: got %h, need %h", n, if_m.dout, e);
               end
            end
         end
         step(s, v, sy, rdy);
         vectors++;
         if (obs_m !== exp_vec(1) || obs_l !== exp_vec(0)) begin
            errors++;
            $display("FAIL rand_%0d: got m=%h l=%h, need m=%h l=%h", n, obs_m, obs_l, exp_vec(1), exp_vec(0));
         end
      end
      reset = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_gap();
      test_overrun();
      test_back_to_back();
      test_sync();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
